// File: rtl/button_debounce.sv
// Pushbutton synchroniser, debouncer, press/release pulser and press counter.
// Optional hold detector enabled by defining LONG_PRESS_EN.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 26,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_state,
  output logic       press,
  // release is a reserved word, hence the suffix
  output logic       release_pulse,
  output logic [7:0] press_count,
  output logic       long_press
);

  typedef enum logic [1:0] {
    RELEASED,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic       s;
  state_t     state;
  state_t     state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic       level_d;
  logic       press_d;
  logic       rel_d;
  logic [7:0] count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= BTN_ACTIVE_LOW;
      sync2 <= BTN_ACTIVE_LOW;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ BTN_ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RELEASED;
      cnt           <= '0;
      btn_state     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      btn_state     <= level_d;
      press         <= press_d;
      release_pulse <= rel_d;
      press_count   <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = btn_state;
    press_d = 1'b0;
    rel_d   = 1'b0;
    count_d = press_count;
    unique case (state)
      RELEASED: begin
        if (s) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!s) begin
          state_d = RELEASED;
        end else if (cnt == DB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = press_count + 8'd1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      ARM_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt == DB_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT =
    CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] lcnt_d;
  logic             long_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      lcnt       <= lcnt_d;
      long_press <= long_d;
    end
  end

  // Counter parks one past the trigger value so the pulse fires once
  always_comb begin
    lcnt_d = lcnt;
    long_d = 1'b0;
    if (state == ARM_PRESS && state_d == PRESSED) begin
      lcnt_d = '0;
    end else if (state_d == RELEASED) begin
      lcnt_d = '0;
    end else if (state == PRESSED || state == ARM_RELEASE) begin
      if (lcnt != LONG_SAT) begin
        lcnt_d = lcnt + 1'b1;
      end
      long_d = (lcnt == LONG_LAST);
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule
